btn_event_sequencer: RTL
========================

// Module: btn_event_sequencer
//
// PURPOSE
//  Front-end controller for the safe's keypad. It synchronizes and debounces
//  the four active-low buttons, arbitrates simultaneous presses and sequences
//  each press into a single event delivered on release. Delivery uses a
//  valid/ready handshake. It sits between the board buttons and the safe-crack
//  FSM, so the FSM sees exactly one clean event per physical press/release.
//
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  stable cycles required to accept a press or a
//                              release (20 ms @ 50 MHz); must be >= 1
//  CNT_W  $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived)
//
// PORTS
//  clk       in   1  system clock, single clock domain
//  rst       in   1  synchronous, active-high reset
//  btn       in   4  raw buttons, active-low (4'b1111 = none pressed), async
//  ev_ready  in   1  consumer accepts the event when ev_valid && ev_ready
//  ev_valid  out  1  event pending; held until accepted
//  ev_code   out  4  one-cold code of the accepted button (e.g. 4'b1101 = BTN1)
//  ev_multi  out  1  more than one button was down at press acceptance
//  busy      out  1  high whenever state != IDLE
//
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE, sync flops=4'b1111, cnt=0,
//    ev_valid=0, ev_code=4'b1111, ev_multi=0, busy=0. rst wins over all events,
//    including a pending unaccepted event, which is dropped.
//  Sync: 2-flop synchronizer, btn -> btn_s (2-cycle latency). All decisions
//    use btn_s only.
//  FSM (registered, next-state comb):
//   IDLE   : btn_s!=4'b1111 -> DB_PR; cap<=btn_s; cnt<=0.
//   DB_PR  : btn_s!=cap -> IDLE (bounce/change, no event).
//            else cnt==DEBOUNCE_CYCLES-1 -> HELD; latch code/multi from cap.
//            else cnt++.
//   HELD   : btn_s==4'b1111 -> DB_RL; cnt<=0. Extra presses here are ignored.
//   DB_RL  : btn_s!=4'b1111 -> HELD (release bounce).
//            else cnt==DEBOUNCE_CYCLES-1 -> EMIT; ev_valid<=1.
//            else cnt++.
//   EMIT   : ev_valid=1; ev_code/ev_multi stable; btn ignored.
//            ev_ready=1 -> IDLE; ev_valid<=0 on the same edge.
//  Arbitration at DB_PR->HELD: code = one-cold of the LOWEST index with cap
//    bit 0 (cap=4'b1010 -> 4'b1110). ev_multi = (count of zeros in cap >= 2).
//  ev_code/ev_multi are updated only on DB_PR->HELD; they hold their value
//    otherwise (ev_code reads meaningful only while ev_valid=1).
//  Latency: ev_valid rises at the (DEBOUNCE_CYCLES+3)th posedge after a raw
//    release that stays stable; one event per press; no event for presses
//    shorter than DEBOUNCE_CYCLES.
//  Back-pressure: ev_ready low holds EMIT indefinitely. A press during EMIT is
//    debounced only after return to IDLE. If it is still held then, it is
//    treated as a new press.
//  cnt never exceeds DEBOUNCE_CYCLES-1; no wrap. DEBOUNCE_CYCLES=1 accepts on
//    the first stable cycle.
//
// TESTING (bench uses DEBOUNCE_CYCLES=4, ev_ready=1 unless stated)
//  1 Reset: rst=1 for 2 cycles, btn=4'b1111 -> ev_valid=0, ev_code=4'b1111,
//    busy=0.
//  2 Clean press: btn=4'b1101 for 10 cycles, then 4'b1111 -> exactly one
//    ev_valid pulse 7 posedges after release; ev_code=4'b1101, ev_multi=0.
//  3 Bounce: btn toggles 4'b1110/4'b1111 every 2 cycles for 20 cycles, then
//    4'b1111 -> no event. A 3-cycle press -> no event.
//  4 Multi: btn=4'b0101 held 10 cycles, release -> ev_code=4'b1101,
//    ev_multi=1.
//  5 Back-pressure: ev_ready=0 for 20 cycles after ev_valid -> ev_valid and
//    ev_code stay stable; ev_ready=1 -> valid drops next edge, busy=0.
//  6 Reset mid-op: rst=1 while in HELD and again in EMIT -> IDLE, ev_valid=0,
//    no event emitted later.

Source files
------------

// File: rtl/btn_event_sequencer_if.sv
// Event handshake between the keypad front-end (master) and its consumer (slave).
interface btn_event_sequencer_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_code;
  logic       ev_multi;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_multi,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_multi,
    output ev_ready
  );
endinterface

// File: rtl/btn_event_sequencer.sv
// Keypad front-end: synchronizes and debounces four active-low buttons, and
// delivers one arbitrated event per press, on release, over valid/ready.
module btn_event_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            btn,
  btn_event_sequencer_if.master ev,
  output logic                  busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DB_PR = 3'd1;
  localparam logic [2:0] HELD  = 3'd2;
  localparam logic [2:0] DB_RL = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, btn_s_q;
  logic [2:0]       state_q, state_d;
  logic [3:0]       cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [3:0]       code_q, code_d;
  logic             multi_q, multi_d;

  logic [3:0]       arb_code;
  logic             arb_multi;
  logic [2:0]       zeros;
  logic             found;

  // Lowest-index pressed button wins; multi flags two or more held together.
  always_comb begin
    arb_code = '1;
    zeros    = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!cap_q[i]) begin
        if (!found) arb_code[i] = 1'b0;
        found = 1'b1;
        zeros = zeros + 3'd1;
      end
    end
    arb_multi = (zeros >= 3'd2);
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    code_d  = code_q;
    multi_d = multi_q;
    case (state_q)
      IDLE: begin
        if (btn_s_q != 4'b1111) begin
          state_d = DB_PR;
          cap_d   = btn_s_q;
          cnt_d   = '0;
        end
      end
      DB_PR: begin
        if (btn_s_q != cap_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          code_d  = arb_code;
          multi_d = arb_multi;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (btn_s_q == 4'b1111) begin
          state_d = DB_RL;
          cnt_d   = '0;
        end
      end
      DB_RL: begin
        if (btn_s_q != 4'b1111) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = EMIT;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EMIT: begin
        if (ev.ev_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      btn_s_q <= '1;
      state_q <= IDLE;
      cap_q   <= '1;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '1;
      multi_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      btn_s_q <= sync1_q;
      state_q <= state_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      multi_q <= multi_d;
    end
  end

  assign ev.ev_valid = valid_q;
  assign ev.ev_code  = code_q;
  assign ev.ev_multi = multi_q;
  assign busy        = (state_q != IDLE);

endmodule
